tt_um_load_stream: RTL and testbench

Parametrised successor to the ternary weight loader. It accepts weight bit-planes over a valid/ready stream, one beat per (output row, bit) pair, and assembles them into a flat weight bus for the ternary matrix-vector datapath. The active row count is set per load. Loads are bracketed by start / done / abort control. Optionally, a shadow bank lets the datapath keep computing on old weights while new ones stream in.

---
 rtl/tt_um_load_stream_if.sv | 29 ++
 rtl/tt_um_load_stream.sv | 175 +++++++++++++++++
 tb/tb_tt_um_load_stream.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_load_stream_if.sv
// Load-stream bundle: start/abort control, the weight bit-plane stream and
// the assembled weight bus, with producer (master) and loader (slave) views.
interface tt_um_load_stream_if #(
    parameter int MAX_IN_LEN   = 16,
    parameter int MAX_OUT_LEN  = 8,
    parameter int WIDTH        = 2,
    parameter int MAX_OUT_BITS = $clog2(MAX_OUT_LEN)
);
    logic                                    start;
    logic                                    abort;
    logic [MAX_OUT_BITS-1:0]                 cfg_out_len;
    logic                                    in_valid;
    logic [MAX_IN_LEN-1:0]                   in_data;
    logic                                    in_ready;
    logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0] uo_weights;
    logic [MAX_OUT_BITS-1:0]                 uo_out_len;
    logic                                    uo_busy;
    logic                                    uo_done;

    modport master (
        output start, abort, cfg_out_len, in_valid, in_data,
        input  in_ready, uo_weights, uo_out_len, uo_busy, uo_done
    );

    modport slave (
        input  start, abort, cfg_out_len, in_valid, in_data,
        output in_ready, uo_weights, uo_out_len, uo_busy, uo_done
    );
endinterface

// File: rtl/tt_um_load_stream.sv
// Ternary weight loader: assembles per-(row,bit) bit-plane beats into a flat weight bus.
// Define LOAD_DOUBLE_BUFFER_EN to stream into a shadow bank committed at the end of DONE.
module tt_um_load_stream #(
    parameter int MAX_IN_LEN   = 16,
    parameter int MAX_OUT_LEN  = 8,
    parameter int WIDTH        = 2,
    parameter int MAX_OUT_BITS = $clog2(MAX_OUT_LEN),
    parameter int CNT_BITS     = $clog2(MAX_OUT_LEN*WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    tt_um_load_stream_if.slave bus
);
    localparam int TOTAL    = WIDTH*MAX_IN_LEN*MAX_OUT_LEN;
    localparam int IDX_BITS = $clog2(TOTAL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    start_acc_s;
    logic                    beat_acc_s;
    logic                    commit_s;
    logic                    last_beat_s;
    logic [CNT_BITS-1:0]     cnt_r;
    logic [CNT_BITS-1:0]     last_cnt_r;
    logic [MAX_OUT_BITS-1:0] cfg_r;
    logic [TOTAL-1:0]        wr_bank_r;
    logic [TOTAL-1:0]        bank_nxt_s;
    logic [TOTAL-1:0]        weights_s;
    logic [IDX_BITS-1:0]     idx_s;
    int                      row_s;
    int                      bit_s;
    logic [MAX_OUT_BITS-1:0] out_len_r;
    logic                    busy_r;
    logic                    done_r;

    assign last_beat_s = (cnt_r == last_cnt_r);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and transfer strobes; ena low freezes everything
    always_comb begin
        state_nxt_s = state_r;
        start_acc_s = 1'b0;
        beat_acc_s  = 1'b0;
        commit_s    = 1'b0;
        if (ena) begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_nxt_s = ST_LOAD;
                        start_acc_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // abort wins over a coincident beat, which is dropped
                    if (bus.abort) begin
                        state_nxt_s = ST_IDLE;
                    end else if (bus.in_valid) begin
                        beat_acc_s  = 1'b1;
                        state_nxt_s = last_beat_s ? ST_DONE : ST_LOAD;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                    commit_s    = ~bus.abort;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Beat counter and per-load configuration; the counter saturates on the last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            last_cnt_r <= '0;
            cfg_r      <= '0;
        end else if (start_acc_s) begin
            cnt_r      <= '0;
            last_cnt_r <= CNT_BITS'((int'(bus.cfg_out_len) + 1) * WIDTH - 1);
            cfg_r      <= bus.cfg_out_len;
        end else if (beat_acc_s && !last_beat_s) begin
            cnt_r      <= cnt_r + CNT_BITS'(1);
        end else begin
            cnt_r      <= cnt_r;
        end
    end

    // Next contents of the bank being written: cleared on start, one bit-plane per beat
    always_comb begin
        bank_nxt_s = wr_bank_r;
        idx_s      = '0;
        row_s      = int'(cnt_r) / WIDTH;
        bit_s      = int'(cnt_r) % WIDTH;
        if (start_acc_s) begin
            bank_nxt_s = '0;
        end else if (beat_acc_s) begin
            for (int i = 0; i < MAX_IN_LEN; i++) begin
                idx_s             = IDX_BITS'((i*MAX_OUT_LEN + row_s)*WIDTH + bit_s);
                bank_nxt_s[idx_s] = bus.in_data[i];
            end
        end else begin
            bank_nxt_s = wr_bank_r;
        end
    end

    // Write bank register (shadow when double-buffered, otherwise the visible bank)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_r <= '0;
        end else begin
            wr_bank_r <= bank_nxt_s;
        end
    end

`ifdef LOAD_DOUBLE_BUFFER_EN
    logic [TOTAL-1:0] active_r;

    // Active bank takes the whole shadow at once when DONE completes
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r <= '0;
        end else if (commit_s) begin
            active_r <= wr_bank_r;
        end else begin
            active_r <= active_r;
        end
    end

    assign weights_s = active_r;
`else
    assign weights_s = wr_bank_r;
`endif

    // Registered status outputs, tracking the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            out_len_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            out_len_r <= commit_s ? cfg_r : out_len_r;
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    assign bus.in_ready   = ena & (state_r == ST_LOAD);
    assign bus.uo_weights = weights_s;
    assign bus.uo_out_len = out_len_r;
    assign bus.uo_busy    = busy_r;
    assign bus.uo_done    = done_r;
endmodule

// File: tb/tb_tt_um_load_stream.sv
// Randomised self-checking bench for tt_um_load_stream against a weight-array model.
// Honours LOAD_DOUBLE_BUFFER_EN the same way the design does.
module tb_tt_um_load_stream;
    localparam int MI  = 16;
    localparam int MO  = 8;
    localparam int W   = 2;
    localparam int OB  = $clog2(MO);
    localparam int TOT = W*MI*MO;

    logic clk;
    logic rst;
    logic ena;

    tt_um_load_stream_if #(.MAX_IN_LEN(MI), .MAX_OUT_LEN(MO), .WIDTH(W), .MAX_OUT_BITS(OB)) bus ();

    tt_um_load_stream #(.MAX_IN_LEN(MI), .MAX_OUT_LEN(MO), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;

    // Model: phase 0 = idle, 1 = streaming, 2 = completion cycle
    int             phase = 0;
    int             m_k = 0;
    int             m_len = 0;
    int             m_out_len = 0;
    logic [W-1:0]   m_act [MI][MO];
    logic [W-1:0]   m_shd [MI][MO];
    logic [MI-1:0]  beat_data [MO*W];

    task automatic check(input string nm, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [TOT-1:0] model_flat();
        logic [TOT-1:0] v;
        v = '0;
        for (int i = 0; i < MI; i++)
            for (int o = 0; o < MO; o++)
                v[(i*MO+o)*W +: W] = m_act[i][o];
        return v;
    endfunction

    function automatic logic [W-1:0] get_w(input int i, input int o);
        return bus.uo_weights[(i*MO+o)*W +: W];
    endfunction

    task automatic model_clear_all();
        for (int i = 0; i < MI; i++)
            for (int o = 0; o < MO; o++) begin
                m_act[i][o] = '0;
                m_shd[i][o] = '0;
            end
    endtask

    // Behavioural reference, evaluated on every rising edge from the driven inputs
    always @(posedge clk) begin
        if (rst) begin
            model_clear_all();
            phase = 0; m_k = 0; m_len = 0; m_out_len = 0;
        end else if (ena) begin
            if (phase == 0) begin
                if (bus.start) begin
                    m_len = int'(bus.cfg_out_len);
                    m_k   = 0;
                    for (int i = 0; i < MI; i++)
                        for (int o = 0; o < MO; o++) begin
`ifdef LOAD_DOUBLE_BUFFER_EN
                            m_shd[i][o] = '0;
`else
                            m_act[i][o] = '0;
`endif
                        end
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (bus.abort) begin
                    phase = 0;
                end else if (bus.in_valid) begin
                    for (int i = 0; i < MI; i++) begin
`ifdef LOAD_DOUBLE_BUFFER_EN
                        m_shd[i][m_k / W][m_k % W] = bus.in_data[i];
`else
                        m_act[i][m_k / W][m_k % W] = bus.in_data[i];
`endif
                    end
                    m_k++;
                    if (m_k == (m_len + 1) * W) phase = 2;
                end
            end else begin
                if (!bus.abort) begin
                    m_out_len = m_len;
`ifdef LOAD_DOUBLE_BUFFER_EN
                    for (int i = 0; i < MI; i++)
                        for (int o = 0; o < MO; o++)
                            m_act[i][o] = m_shd[i][o];
`endif
                end
                phase = 0;
            end
        end
    end

    // Single compare point, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",   TOT'(bus.in_ready),   TOT'((phase == 1) && ena));
            check("uo_busy",    TOT'(bus.uo_busy),    TOT'(phase != 0));
            check("uo_done",    TOT'(bus.uo_done),    TOT'(phase == 2));
            check("uo_out_len", TOT'(bus.uo_out_len), TOT'(m_out_len));
            check("uo_weights", bus.uo_weights,       model_flat());
            if (bus.uo_done) done_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic run_load(input int cfg, input bit noisy, input int abort_at);
        int  n;
        int  sent;
        int  budget;
        int  w;
        bit  acc;
        n = (cfg + 1) * W;
        sent = 0;
        budget = 0;
        ena = 1'b1;
        bus.start = 1'b1;
        bus.cfg_out_len = OB'(cfg);
        bus.in_valid = 1'b0;
        cyc();
        bus.start = 1'b0;
        while (sent < n && budget < 400) begin
            ena          = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_valid = noisy ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_data  = beat_data[sent];
            bus.start    = noisy ? ($urandom_range(0, 7) == 0) : 1'b0;
            bus.cfg_out_len = OB'($urandom_range(0, MO-1));
            bus.abort    = (sent == abort_at);
            if (sent == abort_at) ena = 1'b1;
            acc = ena && bus.in_valid && (phase == 1) && !bus.abort;
            cyc();
            budget++;
            if (sent == abort_at) break;
            if (acc) sent++;
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        ena = 1'b1;
        if (abort_at < 0) check("load_timeout", TOT'(sent), TOT'(n));
        w = 0;
        while (phase != 0 && w < 10) begin
            cyc();
            w++;
        end
        check("return_idle", TOT'(phase), TOT'(0));
    endtask

    task automatic pattern_a5();
        for (int k = 0; k < MO*W; k++)
            beat_data[k] = (k % 2 == 0) ? 16'hA5A5 : 16'h0F0F;
    endtask

    task automatic check_a5_literals(input string tag);
        check({tag, "_w0"}, TOT'(get_w(0, 0)), TOT'(2'd3));
        check({tag, "_w1"}, TOT'(get_w(1, 7)), TOT'(2'd2));
        check({tag, "_w2"}, TOT'(get_w(2, 3)), TOT'(2'd3));
        check({tag, "_w4"}, TOT'(get_w(4, 5)), TOT'(2'd0));
        check({tag, "_w5"}, TOT'(get_w(5, 7)), TOT'(2'd1));
        check({tag, "_w8"}, TOT'(get_w(8, 1)), TOT'(2'd3));
    endtask

    initial begin
        int d0;
        int cfg;
        int ab;
        logic [TOT-1:0] hi_rows;
        rst = 1'b1; ena = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_out_len = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        model_clear_all();
        cyc();
        chk_en = 1'b1;
        cyc();
        check("rst_weights", bus.uo_weights, '0);
        check("rst_ready",   TOT'(bus.in_ready), TOT'(1'b0));
        check("rst_outlen",  TOT'(bus.uo_out_len), TOT'(0));
        rst = 1'b0;
        cyc();

        // Full load, alternating A5A5 / 0F0F
        pattern_a5();
        d0 = done_cnt;
        run_load(7, 1'b0, -1);
        check("full_done_once", TOT'(done_cnt - d0), TOT'(1));
        check("full_outlen",    TOT'(bus.uo_out_len), TOT'(3'd7));
        check_a5_literals("full");

        // Partial load of 3 rows
        for (int k = 0; k < MO*W; k++) beat_data[k] = MI'($urandom);
        d0 = done_cnt;
        run_load(2, 1'b0, -1);
        hi_rows = '0;
        for (int i = 0; i < MI; i++)
            for (int o = 3; o < MO; o++)
                hi_rows[(i*MO+o)*W +: W] = get_w(i, o);
        check("partial_rows_zero", hi_rows, '0);
        check("partial_outlen",    TOT'(bus.uo_out_len), TOT'(3'd2));
        check("partial_done_once", TOT'(done_cnt - d0), TOT'(1));

        // Same full load under random backpressure, ena gaps and stray starts
        pattern_a5();
        run_load(7, 1'b1, -1);
        check_a5_literals("bp");
        check("bp_outlen", TOT'(bus.uo_out_len), TOT'(3'd7));

        // Abort coincident with the sixth all-ones beat
        for (int k = 0; k < MO*W; k++) beat_data[k] = 16'hFFFF;
        d0 = done_cnt;
        run_load(7, 1'b0, 5);
        check("abort_no_done", TOT'(done_cnt - d0), TOT'(0));
        check("abort_idle",    TOT'(bus.uo_busy), TOT'(1'b0));
        check("abort_outlen",  TOT'(bus.uo_out_len), TOT'(3'd7));
`ifdef LOAD_DOUBLE_BUFFER_EN
        check_a5_literals("abort");
`else
        check("abort_r0", TOT'(get_w(7, 0)), TOT'(2'd3));
        check("abort_r1", TOT'(get_w(7, 1)), TOT'(2'd3));
        check("abort_r2", TOT'(get_w(7, 2)), TOT'(2'd1));
        check("abort_r3", TOT'(get_w(7, 3)), TOT'(2'd0));
`endif

        // Reset in the middle of a load
        bus.start = 1'b1; bus.cfg_out_len = OB'(7);
        cyc();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.in_data = MI'($urandom);
            cyc();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        check("midrst_weights", bus.uo_weights, '0);
        check("midrst_busy",    TOT'(bus.uo_busy), TOT'(1'b0));
        check("midrst_ready",   TOT'(bus.in_ready), TOT'(1'b0));
        check("midrst_outlen",  TOT'(bus.uo_out_len), TOT'(0));
        rst = 1'b0;
        cyc();

        // Random loads with occasional aborts
        for (int t = 0; t < 30; t++) begin
            cfg = $urandom_range(0, MO-1);
            for (int k = 0; k < MO*W; k++) beat_data[k] = MI'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (cfg+1)*W-1) : -1;
            run_load(cfg, $urandom_range(0, 1) == 1, ab);
            for (int g = 0; g < $urandom_range(0, 3); g++) cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
